dmem_bridge: RTL and testbench

//  Sits between the CPU data-memory ports and a word-wide, synchronous-read data RAM.

---
 rtl/dmem_bridge.sv | 162 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Bridge between CPU data-memory ports and a word-wide synchronous-read RAM:
// lane steering, load extension, sb/sh read-modify-write and CPU stall control.
module dmem_bridge #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              is_lw,
  input  logic              is_lb,
  input  logic              is_lh,
  input  logic              is_lbu,
  input  logic              is_lhu,
  input  logic              is_sw,
  input  logic              is_sb,
  input  logic              is_sh,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              misalign_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, LD_DONE, RMW_WR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t            state, state_nxt;
  logic [1:0]        off_q, size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;

  logic [31:0] rel;
  logic        unused_hi;
  logic        is_load, is_part_store, misalign;
  logic [1:0]  size_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, merged;

  // Addresses above the RAM simply wrap: only the low word-index bits are kept.
  assign rel       = cpu_addr - BASE_ADDR;
  assign unused_hi = ^rel[31:ADDR_W+2];

  assign is_load       = is_lw | is_lb | is_lh | is_lbu | is_lhu;
  assign is_part_store = is_sb | is_sh;
  assign misalign      = ((is_lw | is_sw) & (|cpu_addr[1:0]))
                       | ((is_lh | is_lhu | is_sh) & cpu_addr[0]);
  assign size_d        = (is_lw | is_sw) ? SZ_WORD :
                         (is_lh | is_lhu | is_sh) ? SZ_HALF : SZ_BYTE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      off_q  <= '0;
      size_q <= '0;
      sign_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req && !misalign && (is_load || is_part_store)) begin
        off_q  <= rel[1:0];
        size_q <= size_d;
        sign_q <= is_lb | is_lh;
        addr_q <= rel[ADDR_W+1:2];
        data_q <= cpu_wdata[15:0];
      end
    end
  end

  // Lane selection for loads and lane replacement for read-modify-write stores.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = ram_rdata[7:0];
      2'd1:    ld_byte = ram_rdata[15:8];
      2'd2:    ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SZ_WORD: ld_ext = ram_rdata;
      SZ_HALF: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
    endcase
    merged = ram_rdata;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    misalign_err = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = rel[ADDR_W+1:2];
    ram_wdata    = cpu_wdata;
    cpu_rdata    = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (misalign) begin
            misalign_err = 1'b1;
          end else if (is_load) begin
            ram_en    = 1'b1;
            stall     = 1'b1;
            state_nxt = LD_DONE;
          end else if (is_sw) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else if (is_part_store) begin
            ram_en    = 1'b1;
            stall     = 1'b1;
            state_nxt = RMW_WR;
          end
        end
      end
      LD_DONE: begin
        cpu_rdata = ld_ext;
        state_nxt = IDLE;
      end
      RMW_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must also kill an in-flight RMW write so no partial word lands in RAM.
    if (rst) begin
      stall        = 1'b0;
      misalign_err = 1'b0;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      cpu_rdata    = '0;
      state_nxt    = IDLE;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge with a behavioural synchronous-read RAM.
module tb_dmem_bridge;

  localparam int          ADDR_W = 11;
  localparam logic [31:0] BASE   = 32'h1001_0000;

  localparam int K_NONE = 0, K_LW = 1, K_LB = 2, K_LH = 3, K_LBU = 4,
                 K_LHU = 5, K_SW = 6, K_SB = 7, K_SH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic              is_lw, is_lb, is_lh, is_lbu, is_lhu, is_sw, is_sb, is_sh;
  logic [31:0]       cpu_rdata;
  logic              stall, misalign_err, ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bw_en;
  logic [ADDR_W-1:0] bw_addr;
  logic [31:0]       bw_data;

  int checks = 0;
  int errors = 0;

  dmem_bridge #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .is_lw(is_lw), .is_lb(is_lb), .is_lh(is_lh), .is_lbu(is_lbu), .is_lhu(is_lhu),
    .is_sw(is_sw), .is_sb(is_sb), .is_sh(is_sh),
    .cpu_rdata(cpu_rdata), .stall(stall), .misalign_err(misalign_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor write port used only for preloading.
  always @(posedge clk) begin
    if (bw_en) mem[bw_addr] <= bw_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic [31:0] wdata, input int kind);
    cpu_req   = req;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    is_lw  = (kind == K_LW);  is_lb  = (kind == K_LB);  is_lh = (kind == K_LH);
    is_lbu = (kind == K_LBU); is_lhu = (kind == K_LHU);
    is_sw  = (kind == K_SW);  is_sb  = (kind == K_SB);  is_sh = (kind == K_SH);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
    bw_en = 1'b1; bw_addr = idx; bw_data = data;
    tick();
    bw_en = 1'b0;
  endtask

  task automatic doLoad(input string tag, input logic [31:0] addr, input int kind,
                        input logic [31:0] expected);
    applyStimulus(1'b1, addr, 32'h0, kind);
    checkOutput({tag, "_stall"}, {31'b0, stall}, 32'd1);
    tick();
    checkOutput({tag, "_nostall"}, {31'b0, stall}, 32'd0);
    checkOutput({tag, "_data"}, cpu_rdata, expected);
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    tick();
  endtask

  initial begin
    bw_en = 1'b0; bw_addr = '0; bw_data = '0;
    rst = 1'b1;
    applyStimulus(1'b1, BASE, 32'h0, K_LW);
    tick();
    checkOutput("rst_stall",   {31'b0, stall},        32'd0);
    checkOutput("rst_ram_en",  {31'b0, ram_en},       32'd0);
    checkOutput("rst_ram_we",  {31'b0, ram_we},       32'd0);
    checkOutput("rst_misal",   {31'b0, misalign_err}, 32'd0);
    checkOutput("rst_rdata",   cpu_rdata,             32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] no-type request");
    applyStimulus(1'b1, BASE, 32'h0, K_NONE);
    checkOutput("nop_stall",  {31'b0, stall},  32'd0);
    checkOutput("nop_ram_en", {31'b0, ram_en}, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);

    $display("[TB] loads");
    preload('0, 32'h8899_AABB);
    applyStimulus(1'b1, BASE + 32'd1, 32'h0, K_LB);
    checkOutput("lb_ram_en",   {31'b0, ram_en}, 32'd1);
    checkOutput("lb_ram_we",   {31'b0, ram_we}, 32'd0);
    checkOutput("lb_ram_addr", 32'(ram_addr),   32'd0);
    checkOutput("lb_stall",    {31'b0, stall},  32'd1);
    tick();
    checkOutput("lb_nostall",  {31'b0, stall},  32'd0);
    checkOutput("lb_data",     cpu_rdata,       32'hFFFF_FFAA);
    checkOutput("lb_noreissue", {31'b0, ram_en}, 32'd0);
    tick();
    checkOutput("lb_held_stall", {31'b0, stall}, 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    tick();
    checkOutput("idle_rdata", cpu_rdata, 32'd0);
    doLoad("lhu", BASE + 32'd2, K_LHU, 32'h0000_8899);
    doLoad("lh",  BASE + 32'd2, K_LH,  32'hFFFF_8899);
    doLoad("lbu", BASE + 32'd1, K_LBU, 32'h0000_00AA);
    doLoad("lh0", BASE,         K_LH,  32'hFFFF_AABB);
    doLoad("lw",  BASE,         K_LW,  32'h8899_AABB);

    $display("[TB] sb read-modify-write");
    preload('0, 32'h1122_3344);
    applyStimulus(1'b1, BASE + 32'd3, 32'hAAAA_AA5C, K_SB);
    checkOutput("sb_stall",  {31'b0, stall},  32'd1);
    checkOutput("sb_rd_we",  {31'b0, ram_we}, 32'd0);
    checkOutput("sb_rd_en",  {31'b0, ram_en}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    checkOutput("sb_wr_stall", {31'b0, stall},  32'd0);
    checkOutput("sb_wr_we",    {31'b0, ram_we}, 32'd1);
    checkOutput("sb_wr_addr",  32'(ram_addr),   32'd0);
    checkOutput("sb_wr_data",  ram_wdata,       32'h5C22_3344);
    tick();
    checkOutput("sb_mem", mem[0], 32'h5C22_3344);
    checkOutput("sb_after_stall", {31'b0, stall}, 32'd0);

    $display("[TB] sw and back-to-back lw");
    applyStimulus(1'b1, BASE + 32'd4, 32'hDEAD_BEEF, K_SW);
    checkOutput("sw_we",    {31'b0, ram_we}, 32'd1);
    checkOutput("sw_stall", {31'b0, stall},  32'd0);
    checkOutput("sw_addr",  32'(ram_addr),   32'd1);
    checkOutput("sw_data",  ram_wdata,       32'hDEAD_BEEF);
    tick();
    doLoad("lw_b2b",  BASE + 32'd4,    K_LW, 32'hDEAD_BEEF);
    doLoad("lw_wrap", BASE + 32'd8196, K_LW, 32'hDEAD_BEEF);

    $display("[TB] misaligned accesses");
    applyStimulus(1'b1, BASE + 32'd2, 32'h0, K_LW);
    checkOutput("mis_lw_err",   {31'b0, misalign_err}, 32'd1);
    checkOutput("mis_lw_en",    {31'b0, ram_en},       32'd0);
    checkOutput("mis_lw_stall", {31'b0, stall},        32'd0);
    checkOutput("mis_lw_rdata", cpu_rdata,             32'd0);
    tick();
    checkOutput("mis_lw_idle", {31'b0, stall}, 32'd0);
    applyStimulus(1'b1, BASE + 32'd1, 32'h0000_7777, K_SH);
    checkOutput("mis_sh_err", {31'b0, misalign_err}, 32'd1);
    checkOutput("mis_sh_en",  {31'b0, ram_en},       32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    checkOutput("mis_err_clear", {31'b0, misalign_err}, 32'd0);
    tick();
    checkOutput("mis_mem", mem[0], 32'h5C22_3344);

    $display("[TB] reset during RMW write");
    preload(11'd2, 32'hCAFE_F00D);
    applyStimulus(1'b1, BASE + 32'd10, 32'h0000_BEEF, K_SH);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    rst = 1'b1;
    #1;
    checkOutput("rst_rmw_we",    {31'b0, ram_we}, 32'd0);
    checkOutput("rst_rmw_stall", {31'b0, stall},  32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_rmw_mem",   mem[2], 32'hCAFE_F00D);
    checkOutput("rst_rmw_idle",  {31'b0, ram_en}, 32'd0);
    applyStimulus(1'b1, BASE + 32'd10, 32'h0000_BEEF, K_SH);
    checkOutput("sh_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, K_NONE);
    tick();
    checkOutput("sh_mem", mem[2], 32'hBEEF_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
